// File: rtl/fifo_core.sv
// fifo_core: single-clock valid/ready FIFO, DEPTH x DATA_W, registered
// outputs on both sides so neither handshake has a combinational path.
// Ports: clk, rst_n (async low); data_in/_vld/_rdy write side;
// data_out/_vld/_rdy read side; level = occupancy 0..DEPTH.
// Optional macro FIFO_CORE_WATERMARK_EN adds registered
// almost_full (level >= AF_LEVEL) and almost_empty (level <= AE_LEVEL).
module fifo_core #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       data_in_vld,
    output logic                       data_in_rdy,
    output logic [DATA_W-1:0]          data_out,
    output logic                       data_out_vld,
    input  logic                       data_out_rdy,
    output logic [$clog2(DEPTH+1)-1:0] level
`ifdef FIFO_CORE_WATERMARK_EN
    ,
    output logic                       almost_full,
    output logic                       almost_empty
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = $clog2(DEPTH+1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
        AF_LEVEL > DEPTH || AE_LEVEL > DEPTH) begin : g_cfg_err
        $error("fifo_core: bad DEPTH/AF_LEVEL/AE_LEVEL");
    end

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_level;
    logic              r_rdy;
    logic              r_vld;
    logic [DATA_W-1:0] r_dout;

    logic              w_push;
    logic              w_pop;
    logic [PW-1:0]     w_wr_nxt;
    logic [PW-1:0]     w_rd_nxt;
    logic [LW-1:0]     w_level_nxt;
    logic              w_empty_nxt;
    logic              w_full_nxt;
    logic [DATA_W-1:0] w_head_nxt;

    // Handshakes only look at registered rdy/vld.
    assign w_push = data_in_vld & r_rdy;
    assign w_pop  = r_vld & data_out_rdy;

    always_comb begin
        w_wr_nxt    = w_push ? r_wr_ptr + PW'(1) : r_wr_ptr;
        w_rd_nxt    = w_pop  ? r_rd_ptr + PW'(1) : r_rd_ptr;
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + LW'(1);
            2'b01:   w_level_nxt = r_level - LW'(1);
            default: w_level_nxt = r_level;
        endcase
        w_empty_nxt = (w_wr_nxt == w_rd_nxt);
        w_full_nxt  = (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]) &&
                      (w_wr_nxt[AW] != w_rd_nxt[AW]);
        // Next head is the word being written this edge when it lands
        // in the slot the read pointer moves to.
        if (w_push && (r_wr_ptr[AW-1:0] == w_rd_nxt[AW-1:0]))
            w_head_nxt = data_in;
        else
            w_head_nxt = r_mem[w_rd_nxt[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_rdy    <= 1'b0;
            r_vld    <= 1'b0;
            r_dout   <= '0;
        end else begin
            if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= data_in;
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_level  <= w_level_nxt;
            r_rdy    <= !w_full_nxt;
            r_vld    <= !w_empty_nxt;
            // When going empty, data_out keeps the last popped word.
            if (!w_empty_nxt) r_dout <= w_head_nxt;
        end
    end

    assign data_in_rdy  = r_rdy;
    assign data_out_vld = r_vld;
    assign data_out     = r_dout;
    assign level        = r_level;

`ifdef FIFO_CORE_WATERMARK_EN
    localparam logic [LW-1:0] AF_L = LW'(AF_LEVEL);
    localparam logic [LW-1:0] AE_L = LW'(AE_LEVEL);

    logic r_af;
    logic r_ae;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_af <= 1'b0;
            r_ae <= 1'b1;
        end else begin
            r_af <= (w_level_nxt >= AF_L);
            r_ae <= (w_level_nxt <= AE_L);
        end
    end

    assign almost_full  = r_af;
    assign almost_empty = r_ae;
`endif

endmodule

// File: tb/tb_fifo_core.sv
// tb_fifo_core: directed bench for fifo_core (DEPTH=8, DATA_W=32).
// Inputs change 1ns after posedge; outputs are checked there too.
module tb_fifo_core;

    logic        clk;
    logic        rst_n;
    logic [31:0] data_in;
    logic        data_in_vld;
    logic        data_in_rdy;
    logic [31:0] data_out;
    logic        data_out_vld;
    logic        data_out_rdy;
    logic [3:0]  level;
`ifdef FIFO_CORE_WATERMARK_EN
    logic        almost_full;
    logic        almost_empty;
`endif

    int n_tot = 0;
    int n_bad = 0;

    fifo_core #(.DATA_W(32), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .data_in_vld  (data_in_vld),
        .data_in_rdy  (data_in_rdy),
        .data_out     (data_out),
        .data_out_vld (data_out_vld),
        .data_out_rdy (data_out_rdy),
        .level        (level)
`ifdef FIFO_CORE_WATERMARK_EN
        ,
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n        = 1'b0;
        data_in      = '0;
        data_in_vld  = 1'b0;
        data_out_rdy = 1'b0;
        tick();
        tick();
        chk("rst_vld", 32'(data_out_vld), 32'd0);
        chk("rst_lvl", 32'(level), 32'd0);
        chk("rst_rdy", 32'(data_in_rdy), 32'd0);
        chk("rst_dout", data_out, 32'h0);
`ifdef FIFO_CORE_WATERMARK_EN
        chk("rst_af", 32'(almost_full), 32'd0);
        chk("rst_ae", 32'(almost_empty), 32'd1);
`endif
        rst_n = 1'b1;
        chk("rel_rdy0", 32'(data_in_rdy), 32'd0);
        tick();
        chk("rel_rdy1", 32'(data_in_rdy), 32'd1);

        // single word
        data_in = 32'hDEADBEEF;
        data_in_vld = 1'b1;
        tick();
        data_in_vld = 1'b0;
        chk("one_dout", data_out, 32'hDEADBEEF);
        chk("one_vld", 32'(data_out_vld), 32'd1);
        chk("one_lvl", 32'(level), 32'd1);
        data_out_rdy = 1'b1;
        tick();
        data_out_rdy = 1'b0;
        chk("one_vld0", 32'(data_out_vld), 32'd0);
        chk("one_lvl0", 32'(level), 32'd0);
        chk("one_hold", data_out, 32'hDEADBEEF);
        // empty: rdy ignored
        data_out_rdy = 1'b1;
        tick();
        data_out_rdy = 1'b0;
        chk("emp_lvl", 32'(level), 32'd0);
        chk("emp_dout", data_out, 32'hDEADBEEF);

        // fill 1..8
        for (int i = 1; i <= 8; i++) begin
            data_in = 32'(i);
            data_in_vld = 1'b1;
            tick();
        end
        chk("full_lvl", 32'(level), 32'd8);
        chk("full_rdy", 32'(data_in_rdy), 32'd0);
        chk("full_dout", data_out, 32'h1);
        data_in = 32'h9;
        tick();
        chk("full_hold", 32'(level), 32'd8);

        // pop at full with push pending
        chk("fp_head", data_out, 32'h1);
        data_out_rdy = 1'b1;
        tick();
        data_out_rdy = 1'b0;
        chk("fp_lvl7", 32'(level), 32'd7);
        chk("fp_rdy", 32'(data_in_rdy), 32'd1);
        chk("fp_dout", data_out, 32'h2);
        tick();
        data_in_vld = 1'b0;
        chk("fp_lvl8", 32'(level), 32'd8);
        data_out_rdy = 1'b1;
        for (int k = 2; k <= 9; k++) begin
            chk("fp_order", data_out, 32'(k));
            tick();
        end
        data_out_rdy = 1'b0;
        chk("fp_lvl0", 32'(level), 32'd0);
        chk("fp_vld0", 32'(data_out_vld), 32'd0);

        // streaming at level 3, 100 cycles
        data_in_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_in = 32'h100 + 32'(i);
            tick();
        end
        data_out_rdy = 1'b1;
        for (int i = 0; i < 100; i++) begin
            data_in = 32'h103 + 32'(i);
            chk("st_dout", data_out, 32'h100 + 32'(i));
            chk("st_lvl", 32'(level), 32'd3);
            tick();
        end
        data_in_vld = 1'b0;
        for (int i = 100; i < 103; i++) begin
            chk("st_tail", data_out, 32'h100 + 32'(i));
            tick();
        end
        data_out_rdy = 1'b0;
        chk("st_lvl0", 32'(level), 32'd0);

`ifdef FIFO_CORE_WATERMARK_EN
        // watermarks fill 0->8 then drain
        data_in_vld = 1'b1;
        for (int l = 1; l <= 8; l++) begin
            data_in = 32'h200 + 32'(l);
            tick();
            chk("wm_f_lvl", 32'(level), 32'(l));
            chk("wm_f_af", 32'(almost_full), 32'(l >= 6));
            chk("wm_f_ae", 32'(almost_empty), 32'(l <= 2));
        end
        data_in_vld = 1'b0;
        data_out_rdy = 1'b1;
        for (int l = 7; l >= 0; l--) begin
            tick();
            chk("wm_d_lvl", 32'(level), 32'(l));
            chk("wm_d_af", 32'(almost_full), 32'(l >= 6));
            chk("wm_d_ae", 32'(almost_empty), 32'(l <= 2));
        end
        data_out_rdy = 1'b0;
`endif

        // reset mid-traffic at level 5
        data_in_vld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_in = 32'h300 + 32'(i);
            tick();
        end
        data_in_vld = 1'b0;
        chk("mr_lvl5", 32'(level), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_vld", 32'(data_out_vld), 32'd0);
        chk("mr_lvl", 32'(level), 32'd0);
        chk("mr_rdy", 32'(data_in_rdy), 32'd0);
        chk("mr_dout", data_out, 32'h0);
        tick();
        rst_n = 1'b1;
        chk("mr_rel0", 32'(data_in_rdy), 32'd0);
        tick();
        chk("mr_rel1", 32'(data_in_rdy), 32'd1);
        chk("mr_emp", 32'(data_out_vld), 32'd0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
